// File: rtl/arbitro_memoria.sv
// Arbiter and sequencer for the unified instruction/data memory port of the fetch stage.
// Alternates fetch and data access when both contend, and stalls fetch while the port is busy.
module arbitro_memoria #(
  parameter int LATENCIA = 2,
  parameter int CONT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic reqBusca,
  input  logic reqDado,
  input  logic escreveDado,
  input  logic fonteDado,
  output logic PCescreve,
  output logic c1,
  output logic c2,
  output logic controleMemoria,
  output logic buscaPronta,
  output logic dadoPronto,
  output logic stallIF,
  output logic ocupado
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    DADO   = 2'd2
  } estado_t;

  localparam logic [CONT_W-1:0] CONT_INI = CONT_W'(LATENCIA - 1);
  localparam logic [CONT_W-1:0] CONT_UM  = CONT_W'(1);

  estado_t           r_estado;
  estado_t           w_estado_next;
  logic [CONT_W-1:0] r_cont;
  logic [CONT_W-1:0] w_cont_next;
  logic              r_esc;
  logic              w_esc_next;
  logic              r_fonte;
  logic              w_fonte_next;
  logic              r_ultimo;
  logic              w_ultimo_next;

  logic w_fim;
  logic w_decide;
  logic w_concede_dado;

  // The last cycle of an access doubles as the grant slot, so back-to-back
  // accesses run without an idle bubble.
  assign w_fim    = (r_estado != OCIOSO) && (r_cont == '0);
  assign w_decide = (r_estado == OCIOSO) || w_fim;

  // Data wins a tie unless the previous grant already went to data.
  assign w_concede_dado = reqDado && (!reqBusca || !r_ultimo);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_cont   <= '0;
      r_esc    <= 1'b0;
      r_fonte  <= 1'b0;
      r_ultimo <= 1'b0;
    end else begin
      r_estado <= w_estado_next;
      r_cont   <= w_cont_next;
      r_esc    <= w_esc_next;
      r_fonte  <= w_fonte_next;
      r_ultimo <= w_ultimo_next;
    end
  end

  always_comb begin
    w_estado_next = r_estado;
    w_cont_next   = r_cont;
    w_esc_next    = r_esc;
    w_fonte_next  = r_fonte;
    w_ultimo_next = r_ultimo;

    if (w_decide) begin
      if (w_concede_dado) begin
        w_estado_next = DADO;
        w_cont_next   = CONT_INI;
        w_esc_next    = escreveDado;
        w_fonte_next  = fonteDado;
        w_ultimo_next = 1'b1;
      end else if (reqBusca) begin
        w_estado_next = BUSCA;
        w_cont_next   = CONT_INI;
        w_ultimo_next = 1'b0;
      end else begin
        w_estado_next = OCIOSO;
        w_cont_next   = '0;
      end
    end else if (r_cont != '0) begin
      w_cont_next = r_cont - CONT_UM;
    end
  end

  // Moore decode: outputs depend only on registered state, except stallIF.
  always_comb begin
    c1              = 1'b0;
    c2              = 1'b0;
    controleMemoria = 1'b0;
    buscaPronta     = 1'b0;
    dadoPronto      = 1'b0;
    ocupado         = (r_estado != OCIOSO);

    unique case (r_estado)
      BUSCA: begin
        buscaPronta = (r_cont == '0);
      end
      DADO: begin
        c1              = 1'b1;
        c2              = r_fonte;
        controleMemoria = r_esc;
        dadoPronto      = (r_cont == '0);
      end
      default: begin
      end
    endcase
  end

  assign PCescreve = buscaPronta;
  assign stallIF   = reqBusca && !buscaPronta;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: directed vector table, a LATENCIA=1 sequence and
// randomized traffic checked against a grant/remaining-cycles reference model.
module tb_arbitro_memoria;

  logic clock;
  logic reset;
  logic reqBusca;
  logic reqDado;
  logic escreveDado;
  logic fonteDado;

  logic pcw0, c1_0, c2_0, ctl0, bp0, dp0, st0, oc0;
  logic pcw1, c1_1, c2_1, ctl1, bp1, dp1, st1, oc1;
  logic [7:0] out0;
  logic [7:0] out1;

  int n_checks;
  int n_fail;

  arbitro_memoria #(.LATENCIA(2), .CONT_W(4)) u_dut2 (
    .clock(clock), .reset(reset), .reqBusca(reqBusca), .reqDado(reqDado),
    .escreveDado(escreveDado), .fonteDado(fonteDado),
    .PCescreve(pcw0), .c1(c1_0), .c2(c2_0), .controleMemoria(ctl0),
    .buscaPronta(bp0), .dadoPronto(dp0), .stallIF(st0), .ocupado(oc0)
  );

  arbitro_memoria #(.LATENCIA(1), .CONT_W(4)) u_dut1 (
    .clock(clock), .reset(reset), .reqBusca(reqBusca), .reqDado(reqDado),
    .escreveDado(escreveDado), .fonteDado(fonteDado),
    .PCescreve(pcw1), .c1(c1_1), .c2(c2_1), .controleMemoria(ctl1),
    .buscaPronta(bp1), .dadoPronto(dp1), .stallIF(st1), .ocupado(oc1)
  );

  // Output vector order: c1 c2 controleMemoria PCescreve buscaPronta dadoPronto stallIF ocupado
  assign out0 = {c1_0, c2_0, ctl0, pcw0, bp0, dp0, st0, oc0};
  assign out1 = {c1_1, c2_1, ctl1, pcw1, bp1, dp1, st1, oc1};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit busy;
    bit dado;
    int rem;
    bit ult;
    bit esc;
    bit fonte;
  } mdl_t;

  typedef struct {
    bit         rst;
    bit         rb;
    bit         rd;
    bit         e;
    bit         f;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] mdl_out(mdl_t m, bit rb);
    bit fin, bp, dp;
    fin = m.busy && (m.rem == 1);
    bp  = fin && !m.dado;
    dp  = fin && m.dado;
    return {m.busy && m.dado, m.busy && m.dado && m.fonte, m.busy && m.dado && m.esc,
            bp, bp, dp, rb && !bp, m.busy};
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int lat, bit rst, bit rb, bit rd, bit e, bit f);
    mdl_t n;
    n = m;
    if (rst) begin
      n = '{busy: 1'b0, dado: 1'b0, rem: 0, ult: 1'b0, esc: 1'b0, fonte: 1'b0};
    end else if (m.busy && m.rem > 1) begin
      n.rem = m.rem - 1;
    end else if (rd && (!rb || !m.ult)) begin
      n = '{busy: 1'b1, dado: 1'b1, rem: lat, ult: 1'b1, esc: e, fonte: f};
    end else if (rb) begin
      n.busy = 1'b1;
      n.dado = 1'b0;
      n.rem  = lat;
      n.ult  = 1'b0;
    end else begin
      n.busy = 1'b0;
      n.rem  = 0;
    end
    return n;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b required %b", name, idx, got, exp);
    end else begin
      $display("ok   %s[%0d]: %b", name, idx, got);
    end
  endtask

  task automatic drive(input bit rst, input bit rb, input bit rd, input bit e, input bit f);
    reset       = rst;
    reqBusca    = rb;
    reqDado     = rd;
    escreveDado = e;
    fonteDado   = f;
  endtask

  vec_t vecs[21];
  mdl_t m2, m1;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;

    vecs[0]  = '{1, 0, 0, 0, 0, 8'b00000000};
    vecs[1]  = '{0, 1, 0, 0, 0, 8'b00000010};
    vecs[2]  = '{0, 1, 0, 0, 0, 8'b00000011};
    vecs[3]  = '{0, 1, 0, 0, 0, 8'b00011001};
    vecs[4]  = '{0, 1, 0, 0, 0, 8'b00000011};
    vecs[5]  = '{0, 0, 0, 0, 0, 8'b00011001};
    vecs[6]  = '{0, 0, 1, 1, 1, 8'b00000000};
    vecs[7]  = '{0, 0, 1, 1, 1, 8'b11100001};
    vecs[8]  = '{0, 0, 0, 1, 1, 8'b11100101};
    vecs[9]  = '{0, 1, 1, 0, 0, 8'b00000010};
    vecs[10] = '{0, 1, 1, 0, 0, 8'b00000011};
    vecs[11] = '{0, 1, 1, 0, 0, 8'b00011001};
    vecs[12] = '{0, 1, 1, 1, 1, 8'b10000011};
    vecs[13] = '{0, 1, 1, 1, 1, 8'b10000111};
    vecs[14] = '{0, 1, 1, 0, 0, 8'b00000011};
    vecs[15] = '{0, 0, 1, 1, 0, 8'b00011001};
    vecs[16] = '{1, 1, 1, 1, 0, 8'b10100011};
    vecs[17] = '{0, 1, 0, 0, 0, 8'b00000010};
    vecs[18] = '{0, 0, 0, 0, 0, 8'b00000001};
    vecs[19] = '{0, 0, 0, 0, 0, 8'b00011001};
    vecs[20] = '{0, 0, 0, 0, 0, 8'b00000000};

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].rb, vecs[i].rd, vecs[i].e, vecs[i].f);
      @(negedge clock);
      check("vec_lat2", i, out0, vecs[i].exp);
      @(posedge clock);
      #1;
    end

    // Contention from reset: DADO first, then strict alternation, prontos 2 cycles apart.
    drive(1, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] exp;
      drive(0, 1, 1, 0, 0);
      case (i)
        0:       exp = 8'b00000010;
        1, 5:    exp = 8'b10000011;
        2, 6:    exp = 8'b10000111;
        3, 7:    exp = 8'b00000011;
        default: exp = 8'b00011001;
      endcase
      @(negedge clock);
      check("alternate", i, out0, exp);
      @(posedge clock);
      #1;
    end

    // LATENCIA=1 with fetch held: pronto every cycle after the first edge.
    drive(1, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      drive(0, (i < 6), 0, 0, 0);
      if (i == 0)      exp = 8'b00000010;
      else if (i < 7)  exp = 8'b00011001;
      else             exp = 8'b00000000;
      @(negedge clock);
      check("lat1_fetch", i, out1, exp);
      @(posedge clock);
      #1;
    end

    // Randomized traffic against the reference model, both latencies at once.
    drive(1, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    m2 = '{busy: 1'b0, dado: 1'b0, rem: 0, ult: 1'b0, esc: 1'b0, fonte: 1'b0};
    m1 = m2;
    for (int i = 0; i < 600; i++) begin
      bit rst, rb, rd, e, f;
      rst = ($urandom_range(0, 40) == 0);
      rb  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 2) != 0);
      e   = 1'($urandom_range(0, 1));
      f   = 1'($urandom_range(0, 1));
      drive(rst, rb, rd, e, f);
      @(negedge clock);
      check("rand_lat2", i, out0, mdl_out(m2, rb));
      check("rand_lat1", i, out1, mdl_out(m1, rb));
      @(posedge clock);
      m2 = mdl_step(m2, 2, rst, rb, rd, e, f);
      m1 = mdl_step(m1, 1, rst, rb, rd, e, f);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Controller and arbiter for the single unified instruction/data memory used by the fetch stage.
- Shares that one memory port between instruction fetch (PC address) and data load/store (ALU address).
- Drives the fetch-stage controls: PCescreve, c1 (address mux), c2 (write-data mux) and controleMemoria (write enable).
- Sequences multi-cycle memory accesses and stalls fetch while the port is busy.

Parameters:
LATENCIA, 2, memory access length in clock cycles (legal range 1..15).
CONT_W, 4, width of the internal wait-state counter (must hold LATENCIA-1).

Ports:
clock  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
reqBusca  in  1  instruction fetch request (level; held until buscaPronta).
reqDado  in  1  data access request from MEM stage (level; held until dadoPronto).
escreveDado  in  1  data request type: 1 = store, 0 = load; sampled at grant.
fonteDado  in  1  store data source: 0 = register file (data1), 1 = MEM/WB (data2); sampled at grant.
PCescreve  out  1  PC load enable, pulsed on fetch completion.
c1  out  1  address mux select: 1 = ALU address (data), 0 = PC (fetch).
c2  out  1  write-data mux select, the latched fonteDado.
controleMemoria  out  1  memory write enable: 1 = write.
buscaPronta  out  1  one-cycle pulse: instruction valid on saidaMemoria.
dadoPronto  out  1  one-cycle pulse: load data valid / store committed.
stallIF  out  1  reqBusca && !buscaPronta.
ocupado  out  1  1 when the state is not OCIOSO.

Behaviour:
- One clock: clock. Reset is synchronous and active-high, named reset; no asynchronous paths.
- States: OCIOSO, BUSCA, DADO.
- Registers: state, cont[CONT_W-1:0], escLatch, fonteLatch, ultimoDado (fairness flag).
- Reset: state=OCIOSO, cont=0, escLatch=0, fonteLatch=0, ultimoDado=0.
- After reset, every output is 0 (stallIF follows reqBusca).
- Grant decision is evaluated at a rising edge in OCIOSO, or in the final cycle of an access:
  - only reqDado -> DADO; only reqBusca -> BUSCA; neither -> OCIOSO.
  - both -> BUSCA if ultimoDado=1, else DADO. Data wins ties unless the previous grant was data, so neither requester starves.
- On grant:
  - cont <= LATENCIA-1.
  - On a DADO grant: escLatch <= escreveDado, fonteLatch <= fonteDado, ultimoDado <= 1.
  - On a BUSCA grant: ultimoDado <= 0.
- In BUSCA or DADO, cont decrements each cycle while cont != 0.
- The final cycle of an access is the one with cont==0.
- Output decode (Moore on state and cont):
  - c1 = (state==DADO).
  - c2 = fonteLatch in DADO, else 0.
  - controleMemoria = (state==DADO) && escLatch, held for the whole access.
  - buscaPronta = PCescreve = (state==BUSCA) && cont==0.
  - dadoPronto = (state==DADO) && cont==0.
- Latency: a request sampled at edge k, with the controller idle, produces its pronto in cycle k+LATENCIA. With LATENCIA=1 the pronto appears in the first cycle of the access state.
- Back-to-back: a new grant is taken at the edge ending the final cycle, so there is no idle bubble between accesses.
- A request dropped mid-access does not abort it: the access completes, the pronto pulses, and the requester ignores it.
- escreveDado and fonteDado changing after grant have no effect.
- Reset mid-access: the next edge forces OCIOSO; no pronto is generated. controleMemoria drops in the cycle after the reset edge, so a partial write is possible and the bench must not check memory contents in that case.
- PCescreve never asserts in DADO, so the PC cannot advance on a data access.

Test Plan:
- LATENCIA=2, reset held 2 cycles, reqBusca=1 from cycle 0 after reset -> BUSCA cycles 1..2, c1=0, buscaPronta=PCescreve=1 only in cycle 2, stallIF=1 in cycle 1, then BUSCA again in cycles 3..4.
- reqDado=1, escreveDado=1, fonteDado=1 at edge k -> c1=1, c2=1, controleMemoria=1 for cycles k+1..k+2, dadoPronto pulse at k+2, PCescreve=0 throughout.
- reqBusca and reqDado both held continuously from reset -> grants alternate DADO, BUSCA, DADO, BUSCA with no idle cycles; each pronto is spaced 2 cycles apart.
- Load grant (escreveDado=0), then escreveDado toggled to 1 during the access -> controleMemoria stays 0 and dadoPronto pulses once.
- reset asserted in the first DADO store cycle -> next cycle state=OCIOSO; all outputs 0 except stallIF, which follows reqBusca; no dadoPronto; ocupado=0.
- LATENCIA=1 with reqBusca held -> buscaPronta high every cycle after the first edge, and ocupado stays 1.
